operand_sequencer: RTL and testbench

- Upstream feeder for the 8-operand compute core (ports i1..i8, start, result, done).
- Accepts operands as a serial valid/ready word stream and parks them in eight holding registers.
- Fires a one-cycle start pulse to the core, waits for done, and captures the result.
- Returns the result downstream on a valid/ready handshake, with a watchdog timeout for a core that never finishes.

---
 rtl/operand_sequencer.sv | 126 ++++++++++++
 tb/tb_operand_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_sequencer.sv
// operand_sequencer: collects eight operand words from a valid/ready stream,
// pulses start to the compute core, waits for done (with a watchdog) and
// returns the captured result on a valid/ready handshake.
module operand_sequencer #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] i1,
  output logic [WIDTH-1:0] i2,
  output logic [WIDTH-1:0] i3,
  output logic [WIDTH-1:0] i4,
  output logic [WIDTH-1:0] i5,
  output logic [WIDTH-1:0] i6,
  output logic [WIDTH-1:0] i7,
  output logic [WIDTH-1:0] i8,
  output logic             start,
  input  logic [WIDTH-1:0] core_result,
  input  logic             core_done,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t           state;
  logic [2:0]       cnt;
  logic [WIDTH-1:0] slot [8];
  logic [WD_W-1:0]  wd;
  logic [WD_W-1:0]  wd_inc;
  logic             timeout_hit;
  logic             accept;

  // in_ready is a decode of the state register, forced low while reset is held
  assign in_ready = (state == LOAD) && !rst;
  assign accept   = in_valid && in_ready;

  assign i1 = slot[0];
  assign i2 = slot[1];
  assign i3 = slot[2];
  assign i4 = slot[3];
  assign i5 = slot[4];
  assign i6 = slot[5];
  assign i7 = slot[6];
  assign i8 = slot[7];

  // Saturating watchdog increment; the timeout fires as the count reaches its last value
  always_comb begin
    wd_inc = (wd == '1) ? wd : wd + WD_W'(1);
  end

  assign timeout_hit = (wd_inc == WD_LAST);

  // Sequencer state, operand slots, watchdog and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= 3'd0;
      for (int k = 0; k < 8; k++) slot[k] <= '0;
      start     <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      wd        <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        LOAD: begin
          if (accept) begin
            slot[cnt] <= in_data;
            cnt       <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              state <= FIRE;
              start <= 1'b1;
              busy  <= 1'b1;
            end
          end
        end
        FIRE: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          wd <= wd_inc;
          // done has priority over a coincident timeout
          if (core_done) begin
            res_data  <= core_result;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state     <= OUT;
          end else if (timeout_hit) begin
            res_data  <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer: cycle table for the basic request,
// hand sequences for bubbles, back-pressure, timeout, done priority and reset.
module tb_operand_sequencer;

  localparam int unsigned W  = 32;
  localparam int unsigned TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] i1, i2, i3, i4, i5, i6, i7, i8;
  logic         start;
  logic [W-1:0] core_result;
  logic         core_done;
  logic [W-1:0] res_data;
  logic         res_err;
  logic         res_valid;
  logic         res_ready;
  logic         busy;

  always #5 clk = ~clk;

  operand_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .i6(i6), .i7(i7), .i8(i8),
    .start(start), .core_result(core_result), .core_done(core_done),
    .res_data(res_data), .res_err(res_err), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy)
  );

  logic [W-1:0] ops [8];
  assign ops[0] = i1;
  assign ops[1] = i2;
  assign ops[2] = i3;
  assign ops[3] = i4;
  assign ops[4] = i5;
  assign ops[5] = i6;
  assign ops[6] = i7;
  assign ops[7] = i8;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] cur_w [8];

  typedef struct {
    logic         rst;
    logic         iv;
    logic [W-1:0] id;
    logic         cd;
    logic [W-1:0] cr;
    logic         rr;
    logic         e_ir;
    logic         e_st;
    logic         e_rv;
    logic         e_busy;
    logic         chk_res;
    logic [W-1:0] e_rd;
    logic         e_err;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic iv, input logic [W-1:0] id,
                     input logic cd, input logic [W-1:0] cr, input logic rr,
                     input logic ir, input logic st, input logic rv, input logic bz,
                     input logic cres, input logic [W-1:0] rd, input logic er);
    vec_t v;
    v.rst = r; v.iv = iv; v.id = id; v.cd = cd; v.cr = cr; v.rr = rr;
    v.e_ir = ir; v.e_st = st; v.e_rv = rv; v.e_busy = bz;
    v.chk_res = cres; v.e_rd = rd; v.e_err = er;
    tbl.push_back(v);
  endtask

  task automatic check_ops(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                           input logic [W-1:0] e2, input logic [W-1:0] e3, input logic [W-1:0] e4,
                           input logic [W-1:0] e5, input logic [W-1:0] e6, input logic [W-1:0] e7);
    logic [W-1:0] e [8];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4; e[5] = e5; e[6] = e6; e[7] = e7;
    for (int k = 0; k < 8; k++) chk($sformatf("%s_i%0d", tag, k + 1), ops[k], e[k]);
  endtask

  // Feed cur_w; optional bubble before each word. Returns in the FIRE cycle.
  task automatic load_req(input bit gaps);
    for (int k = 0; k < 8; k++) begin
      if (gaps) begin
        @(negedge clk); in_valid = 1'b0; in_data = 32'hDEAD_BEEF;
        #1; chk("bubble_start", start, 1'b0);
      end
      @(negedge clk); in_valid = 1'b1; in_data = cur_w[k];
      #1;
      chk($sformatf("load_in_ready_w%0d", k), in_ready, 1'b1);
      chk($sformatf("load_start_w%0d", k), start, 1'b0);
    end
    @(negedge clk); in_valid = 1'b0; in_data = '0;
    #1;
    chk("fire_start", start, 1'b1);
    chk("fire_in_ready", in_ready, 1'b0);
    chk("fire_busy", busy, 1'b1);
  endtask

  // WAIT cycles 1..done_at; done raised in cycle done_at with the given result
  task automatic run_wait(input int done_at, input logic [W-1:0] result);
    for (int c = 1; c <= done_at; c++) begin
      @(negedge clk);
      core_done   = (c == done_at);
      core_result = (c == done_at) ? result : '0;
      #1;
      chk($sformatf("wait_start_c%0d", c), start, 1'b0);
      chk($sformatf("wait_rv_c%0d", c), res_valid, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0;
    core_result = '0; core_done = 1'b0; res_ready = 1'b0;

    // Scenario 1: reset, back-to-back stream, done five cycles after start
    //   rst iv id   cd cr   rr   ir st rv bz cres rd   err
    add(1, 0, 0,    0, 0,   0,   0, 0, 0, 0, 1,  0,   0);
    add(0, 1, 3,    0, 0,   1,   1, 0, 0, 0, 1,  0,   0);
    add(0, 1, 2,    0, 0,   1,   1, 0, 0, 0, 1,  0,   0);
    add(0, 1, 6,    0, 0,   1,   1, 0, 0, 0, 1,  0,   0);
    add(0, 1, 4,    0, 0,   1,   1, 0, 0, 0, 1,  0,   0);
    add(0, 1, 2,    0, 0,   1,   1, 0, 0, 0, 1,  0,   0);
    add(0, 1, 3,    0, 0,   1,   1, 0, 0, 0, 1,  0,   0);
    add(0, 1, 3,    0, 0,   1,   1, 0, 0, 0, 1,  0,   0);
    add(0, 1, 1,    0, 0,   1,   1, 0, 0, 0, 1,  0,   0);
    add(0, 0, 0,    0, 0,   1,   0, 1, 0, 1, 1,  0,   0);
    add(0, 0, 0,    0, 0,   1,   0, 0, 0, 1, 1,  0,   0);
    add(0, 0, 0,    0, 0,   1,   0, 0, 0, 1, 1,  0,   0);
    add(0, 0, 0,    0, 0,   1,   0, 0, 0, 1, 1,  0,   0);
    add(0, 0, 0,    0, 0,   1,   0, 0, 0, 1, 1,  0,   0);
    add(0, 0, 0,    1, 42,  1,   0, 0, 0, 1, 1,  0,   0);
    add(0, 0, 0,    0, 0,   1,   0, 0, 1, 1, 1,  42,  0);
    add(0, 0, 0,    0, 0,   1,   1, 0, 0, 0, 0,  0,   0);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; in_valid = tbl[i].iv; in_data = tbl[i].id;
      core_done = tbl[i].cd; core_result = tbl[i].cr; res_ready = tbl[i].rr;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].e_ir);
      chk($sformatf("v%0d_start", i), start, tbl[i].e_st);
      chk($sformatf("v%0d_res_valid", i), res_valid, tbl[i].e_rv);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      if (tbl[i].chk_res) begin
        chk($sformatf("v%0d_res_data", i), res_data, tbl[i].e_rd);
        chk($sformatf("v%0d_res_err", i), res_err, tbl[i].e_err);
      end
    end
    check_ops("s1", 3, 2, 6, 4, 2, 3, 3, 1);

    // Scenario 2: bubbles on alternate cycles, result back-pressured 4 cycles
    cur_w[0] = 3; cur_w[1] = 2; cur_w[2] = 6; cur_w[3] = 4;
    cur_w[4] = 2; cur_w[5] = 3; cur_w[6] = 3; cur_w[7] = 1;
    res_ready = 1'b0;
    load_req(1'b1);
    check_ops("s2", 3, 2, 6, 4, 2, 3, 3, 1);
    run_wait(5, 42);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      core_done = 1'b0; core_result = '0;
      res_ready = (c == 4);
      #1;
      chk($sformatf("s2_rv_c%0d", c), res_valid, 1'b1);
      chk($sformatf("s2_rd_c%0d", c), res_data, 42);
      chk($sformatf("s2_err_c%0d", c), res_err, 1'b0);
      chk($sformatf("s2_start_c%0d", c), start, 1'b0);
    end
    @(negedge clk); res_ready = 1'b0;
    #1;
    chk("s2_in_ready_after", in_ready, 1'b1);
    chk("s2_rv_after", res_valid, 1'b0);
    check_ops("s2_hold", 3, 2, 6, 4, 2, 3, 3, 1);

    // Scenario 3: core never finishes; timeout result 16 cycles after FIRE
    for (int k = 0; k < 8; k++) cur_w[k] = W'(100 + k);
    load_req(1'b0);
    begin
      int lat;
      lat = 0;
      for (int c = 1; c <= 40 && lat == 0; c++) begin
        @(negedge clk); core_done = 1'b0;
        #1;
        if (res_valid === 1'b1) lat = c;
      end
      chk("s3_timeout_latency", W'(lat), 16);
    end
    chk("s3_err", res_err, 1'b1);
    chk("s3_data", res_data, 0);
    chk("s3_rv", res_valid, 1'b1);
    @(negedge clk); res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
    #1;
    chk("s3_in_ready_after", in_ready, 1'b1);
    check_ops("s3", 100, 101, 102, 103, 104, 105, 106, 107);

    // Scenario 4: done in FIRE ignored; done on final watchdog cycle wins
    for (int k = 0; k < 8; k++) cur_w[k] = W'(200 + k);
    load_req(1'b0);
    core_done = 1'b1; core_result = 99;
    run_wait(15, 77);
    @(negedge clk); core_done = 1'b0; core_result = '0;
    #1;
    chk("s4_rv", res_valid, 1'b1);
    chk("s4_data", res_data, 77);
    chk("s4_err", res_err, 1'b0);
    @(negedge clk); res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
    #1;
    chk("s4_in_ready_after", in_ready, 1'b1);

    // Scenario 5: reset after 3 WAIT cycles, then a clean request
    for (int k = 0; k < 8; k++) cur_w[k] = W'(10 + k);
    load_req(1'b0);
    run_wait(3, 0);
    @(negedge clk); core_done = 1'b0; rst = 1'b1;
    #1;
    chk("s5_in_ready_in_rst", in_ready, 1'b0);
    @(negedge clk); rst = 1'b0;
    #1;
    check_ops("s5_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("s5_start", start, 1'b0);
    chk("s5_rv", res_valid, 1'b0);
    chk("s5_busy", busy, 1'b0);
    chk("s5_in_ready", in_ready, 1'b1);
    for (int k = 0; k < 8; k++) cur_w[k] = W'(21 + k);
    load_req(1'b0);
    run_wait(2, 5);
    @(negedge clk); core_done = 1'b0; core_result = '0; res_ready = 1'b1;
    #1;
    chk("s5_post_rv", res_valid, 1'b1);
    chk("s5_post_data", res_data, 5);
    chk("s5_post_err", res_err, 1'b0);
    @(negedge clk); res_ready = 1'b0;
    #1;
    chk("s5_post_in_ready", in_ready, 1'b1);
    chk("s5_post_busy", busy, 1'b0);
    check_ops("s5_post", 21, 22, 23, 24, 25, 26, 27, 28);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
